// File: rtl/mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : mem_tester
// Brief    : Memory traffic generator/checker. Writes a deterministic pattern
//            over an address window, reads it back and reports mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module mem_tester #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    WORD_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
    parameter int                    COUNT      = 256,
    parameter int                    STRIDE     = 1,
    parameter logic [63:0]           SEED       = 64'h1,
    parameter int                    ERR_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_BITS-1:0]   err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WORD_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_dout,
    input  logic [WORD_WIDTH-1:0] mem_din,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic                  mem_ready
);

    localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int XW = (ADDR_WIDTH > WORD_WIDTH) ? ((ADDR_WIDTH > 64) ? ADDR_WIDTH : 64)
                                                  : ((WORD_WIDTH > 64) ? WORD_WIDTH : 64);
    localparam logic [IW-1:0]         c_last     = IW'(COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_stride   = ADDR_WIDTH'(STRIDE);
    localparam logic [WORD_WIDTH-1:0] c_seed_raw = WORD_WIDTH'(SEED);
    localparam logic [WORD_WIDTH-1:0] c_seed     = (c_seed_raw == '0) ? WORD_WIDTH'(1) : c_seed_raw;
    // Maximal-length Galois taps for the common widths; others get a plain feedback tap.
    localparam logic [WORD_WIDTH-1:0] c_taps =
        (WORD_WIDTH == 64) ? WORD_WIDTH'(64'hD800_0000_0000_0000) :
        (WORD_WIDTH == 32) ? WORD_WIDTH'(32'h8020_0003) :
        (WORD_WIDTH == 16) ? WORD_WIDTH'(16'hB400) :
        (WORD_WIDTH == 8)  ? WORD_WIDTH'(8'hB8) :
                             {1'b1, {(WORD_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [IW-1:0]         r_index;
    logic [WORD_WIDTH-1:0] r_lfsr;
    logic [WORD_WIDTH-1:0] r_rdata;

    logic [WORD_WIDTH-1:0] w_mode0;
    logic [WORD_WIDTH-1:0] w_pattern;
    logic                  w_last;
    logic                  w_mismatch;
    logic [ERR_BITS-1:0]   w_err_next;

    function automatic logic [WORD_WIDTH-1:0] lfsr_step(input logic [WORD_WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? c_taps : '0);
    endfunction

    assign w_mode0    = WORD_WIDTH'(XW'(r_addr) ^ XW'(SEED));
    assign w_pattern  = r_mode ? r_lfsr : w_mode0;
    assign w_last     = (r_index == c_last);
    assign w_mismatch = (r_rdata != w_pattern);
    assign w_err_next = (w_mismatch && (err_count != '1)) ? err_count + ERR_BITS'(1) : err_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_addr    <= '0;
            r_index   <= '0;
            r_lfsr    <= '0;
            r_rdata   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            mem_addr  <= '0;
            mem_dout  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        r_addr    <= BASE;
                        r_index   <= '0;
                        r_lfsr    <= c_seed;
                        r_mode    <= mode;
                        busy      <= 1'b1;
                        r_state   <= S_WR_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    done <= 1'b0;
                    if (mem_ready) begin
                        mem_we   <= 1'b1;
                        mem_addr <= r_addr;
                        mem_dout <= w_pattern;
                        r_state  <= S_WR_WAIT;
                    end
                end
                // The pulse cycle itself is skipped: ready only drops on the accepting edge.
                S_WR_WAIT: begin
                    if (!mem_we && mem_ready) begin
                        if (w_last) begin
                            r_addr  <= BASE;
                            r_index <= '0;
                            r_lfsr  <= c_seed;
                            r_state <= S_RD_ISSUE;
                        end else begin
                            r_addr  <= r_addr + c_stride;
                            r_index <= r_index + IW'(1);
                            r_lfsr  <= lfsr_step(r_lfsr);
                            r_state <= S_WR_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (mem_ready) begin
                        mem_re   <= 1'b1;
                        mem_addr <= r_addr;
                        r_state  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (!mem_re && mem_ready) begin
                        r_rdata <= mem_din;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    err_count <= w_err_next;
                    if (w_mismatch && (err_count == '0)) begin
                        fail_addr <= r_addr;
                        fail_data <= r_rdata;
                    end
                    if (w_last) begin
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                        r_addr  <= BASE;
                        r_index <= '0;
                        r_lfsr  <= c_seed;
                        if (loop) begin
                            r_state <= S_WR_ISSUE;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_addr  <= r_addr + c_stride;
                        r_index <= r_index + IW'(1);
                        r_lfsr  <= lfsr_step(r_lfsr);
                        r_state <= S_RD_ISSUE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_tester.sv
`default_nettype none
// Testbench for mem_tester: table-driven runs against a RAM model with programmable
// latency and a stuck-at-1 data bit, plus wrap-around, loop and mid-test reset sequences.
module tb_mem_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        loop = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [63:0] fail_addr, fail_data, mem_addr, mem_dout, mem_din;
    logic        mem_re, mem_we, mem_ready;

    logic        start_w = 1'b0;
    logic        ready_w = 1'b1;
    logic        busy_w, done_w, pass_w, re_w, we_w;
    logic [15:0] err_w;
    logic [63:0] fa_w, fd_w, addr_w, dout_w, din_w;

    always #5 clk = ~clk;

    mem_tester #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .BASE(64'h0), .COUNT(4),
                 .STRIDE(1), .SEED(64'h0), .ERR_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .loop(loop),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_re(mem_re), .mem_we(mem_we),
        .mem_ready(mem_ready));

    mem_tester #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .BASE(64'hFFFF_FFFF_FFFF_FFFE),
                 .COUNT(4), .STRIDE(1), .SEED(64'h0), .ERR_BITS(16)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .mode(1'b0), .loop(1'b0),
        .busy(busy_w), .done(done_w), .pass(pass_w), .err_count(err_w),
        .fail_addr(fa_w), .fail_data(fd_w), .mem_addr(addr_w),
        .mem_dout(dout_w), .mem_din(din_w), .mem_re(re_w), .mem_we(we_w),
        .mem_ready(ready_w));

    // RAM model: ready drops for lat cycles after each accepted request.
    logic [63:0] mem [16];
    logic        fault = 1'b0;
    int          lat = 0;
    int          wcnt;
    always @(posedge clk) begin
        if (!rst) begin
            mem_ready <= 1'b1;
            wcnt      <= 0;
        end else begin
            if (mem_we && mem_ready) mem[mem_addr[3:0]] <= mem_dout | {63'd0, fault};
            if (mem_re && mem_ready) mem_din <= mem[mem_addr[3:0]];
            if ((mem_we || mem_re) && mem_ready && lat > 0) begin
                mem_ready <= 1'b0;
                wcnt      <= lat - 1;
            end else if (!mem_ready) begin
                if (wcnt == 0) mem_ready <= 1'b1;
                else           wcnt <= wcnt - 1;
            end
        end
    end

    logic [63:0] mem2 [4];
    always @(posedge clk) begin
        if (we_w) mem2[addr_w[1:0]] <= dout_w;
        if (re_w) din_w <= mem2[addr_w[1:0]];
    end

    // Protocol monitor and write logs.
    int cyc = 0;
    int last_issue = -100;
    int viol = 0;
    int loop_pulses = 0;
    logic [63:0] wa_q[$], wd_q[$], wa2_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        viol <= viol + int'(mem_re && mem_we) + int'((mem_re || mem_we) && !mem_ready)
                     + int'((mem_re || mem_we) && (cyc - last_issue < 2))
                     + int'(!rst && (mem_re || mem_we)) + int'(re_w && we_w);
        if (mem_re || mem_we) last_issue <= cyc;
        if (done && busy) loop_pulses <= loop_pulses + 1;
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_dout);
        end
        if (we_w) wa2_q.push_back(addr_w);
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(done && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_done: timed out after %0d cycles", budget);
        end
    endtask

    task automatic run_test(input logic m, input logic xs);
        wa_q.delete();
        wd_q.delete();
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (xs) begin
            repeat (10) @(negedge clk);
            mode  = ~m;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(2000);
        mode = m;
    endtask

    typedef struct packed {
        logic            m;
        logic            flt;
        logic [7:0]      lat;
        logic            xs;
        logic [15:0]     e_err;
        logic            e_pass;
        logic [63:0]     e_fa;
        logic [63:0]     e_fd;
        logic [3:0][63:0] e_wd;
    } vec_t;

    function automatic vec_t mkvec(input logic m, input logic flt, input logic [7:0] lt,
                                   input logic xs, input logic [15:0] e_err, input logic e_pass,
                                   input logic [63:0] e_fa, input logic [63:0] e_fd);
        vec_t v;
        v.m = m; v.flt = flt; v.lat = lt; v.xs = xs;
        v.e_err = e_err; v.e_pass = e_pass; v.e_fa = e_fa; v.e_fd = e_fd;
        if (m) v.e_wd = {64'h3600_0000_0000_0000, 64'h6C00_0000_0000_0000,
                         64'hD800_0000_0000_0000, 64'h1};
        else   v.e_wd = {64'd3, 64'd2, 64'd1, 64'd0};
        return v;
    endfunction

    vec_t vecs [6];

    initial begin
        //                 mode flt lat xs err pass fail_addr fail_data
        vecs[0] = mkvec(0, 0, 0,  0, 0, 1, 64'd0, 64'd0);
        vecs[1] = mkvec(0, 1, 0,  0, 2, 0, 64'd0, 64'd1);
        vecs[2] = mkvec(1, 0, 0,  0, 0, 1, 64'd0, 64'd0);
        vecs[3] = mkvec(1, 1, 20, 0, 3, 0, 64'd1, 64'hD800_0000_0000_0001);
        vecs[4] = mkvec(0, 0, 20, 1, 0, 1, 64'd0, 64'd0);
        vecs[5] = mkvec(0, 0, 3,  0, 0, 1, 64'd0, 64'd0);

        repeat (3) @(negedge clk);
        check("reset outputs", {63'd0, |{busy, done, pass, err_count, fail_addr, fail_data,
                                          mem_addr, mem_dout, mem_re, mem_we}}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fault = vecs[i].flt;
            lat   = int'(vecs[i].lat);
            run_test(vecs[i].m, vecs[i].xs);
            check($sformatf("v%0d done", i), {63'd0, done}, 64'd1);
            check($sformatf("v%0d busy", i), {63'd0, busy}, 64'd0);
            check($sformatf("v%0d pass", i), {63'd0, pass}, {63'd0, vecs[i].e_pass});
            check($sformatf("v%0d err_count", i), {48'd0, err_count}, {48'd0, vecs[i].e_err});
            check($sformatf("v%0d fail_addr", i), fail_addr, vecs[i].e_fa);
            check($sformatf("v%0d fail_data", i), fail_data, vecs[i].e_fd);
            check($sformatf("v%0d write count", i), 64'(wa_q.size()), 64'd4);
            if (wa_q.size() == 4) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("v%0d waddr%0d", i, k), wa_q[k], 64'(k));
                    check($sformatf("v%0d wdata%0d", i, k), wd_q[k], vecs[i].e_wd[k]);
                end
            end
        end

        // Address wrap-around past 2^64-1.
        begin
            int n = 0;
            wa2_q.delete();
            @(negedge clk);
            start_w = 1'b1;
            @(negedge clk);
            start_w = 1'b0;
            while (!(done_w && !busy_w) && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("wrap finished", {63'd0, done_w}, 64'd1);
            check("wrap pass", {63'd0, pass_w}, 64'd1);
            check("wrap err_count", {48'd0, err_w}, 64'd0);
            check("wrap fail_addr", fa_w, 64'd0);
            check("wrap fail_data", fd_w, 64'd0);
            check("wrap write count", 64'(wa2_q.size()), 64'd4);
            if (wa2_q.size() == 4) begin
                check("wrap addr0", wa2_q[0], 64'hFFFF_FFFF_FFFF_FFFE);
                check("wrap addr1", wa2_q[1], 64'hFFFF_FFFF_FFFF_FFFF);
                check("wrap addr2", wa2_q[2], 64'h0);
                check("wrap addr3", wa2_q[3], 64'h1);
            end
        end

        // Looping with a fault: three passes accumulate errors, first failure kept.
        begin
            int n = 0;
            int base_p = loop_pulses;
            fault = 1'b1;
            lat   = 0;
            loop  = 1'b1;
            @(negedge clk);
            mode  = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (loop_pulses - base_p < 2 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("loop two pulses seen", {63'd0, n < 1000}, 64'd1);
            loop = 1'b0;
            wait_done(1000);
            check("loop pulse count", 64'(loop_pulses - base_p), 64'd2);
            check("loop err_count", {48'd0, err_count}, 64'd6);
            check("loop pass", {63'd0, pass}, 64'd0);
            check("loop fail_addr", fail_addr, 64'd0);
            check("loop fail_data", fail_data, 64'd1);
            fault = 1'b0;
        end

        // Reset in the middle of the write phase, then a clean rerun.
        begin
            int n = 0;
            lat = 2;
            wa_q.delete();
            @(negedge clk);
            mode  = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (wa_q.size() < 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("reset test reached writes", 64'(wa_q.size()), 64'd2);
            #2 rst = 1'b0;
            #1;
            check("mid reset outputs", {63'd0, |{busy, done, pass, err_count, fail_addr, fail_data,
                                                  mem_addr, mem_dout, mem_re, mem_we}}, 64'd0);
            repeat (5) @(negedge clk);
            check("held reset re/we", {62'd0, mem_re, mem_we}, 64'd0);
            rst = 1'b1;
            lat = 0;
            run_test(1'b0, 1'b0);
            check("after reset pass", {63'd0, pass}, 64'd1);
            check("after reset err_count", {48'd0, err_count}, 64'd0);
            check("after reset write count", 64'(wa_q.size()), 64'd4);
        end

        repeat (2) @(negedge clk);
        check("protocol violations", 64'(viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
